// File: rtl/mux_unstriping.sv
// Two-lane unstriping receiver: per-lane elastic FIFOs feeding a strict
// lane-0/lane-1 round-robin reader that restores the original word order.
module mux_unstriping #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in1,
  output logic              ready_0,
  output logic              ready_1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              overflow_0,
  output logic              overflow_1,
  output logic              dbg_sel
);

  // Handshake: a lane word is taken on any cycle valid_inN is high; readyN
  // only advertises space. A word arriving with no space is dropped and
  // flagged sticky in overflow_N. valid_out has no back-pressure.

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {LANE0 = 1'b0, LANE1 = 1'b1} sel_e;

  sel_e              sel_q, sel_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;

  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_d [2];
  logic [CNT_W-1:0]  cnt_q    [2];
  logic [CNT_W-1:0]  cnt_d    [2];
  logic              ovf_q    [2];
  logic              ovf_d    [2];

  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [DATA_W-1:0] din   [2];
  logic              vin   [2];
  logic              rd    [2];
  logic              wr    [2];
  logic              sel_idx;

  assign din[0]  = data_in0;
  assign din[1]  = data_in1;
  assign vin[0]  = valid_in0;
  assign vin[1]  = valid_in1;
  assign sel_idx = (sel_q == LANE1);

  // Reads come only from the selected lane; a full lane being read this
  // cycle can still accept a write because the head slot is freed.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      rd[l] = (sel_idx == l[0]) && (cnt_q[l] != '0);
      wr[l] = vin[l] && ((cnt_q[l] != FULL) || rd[l]);
    end
  end

  always_comb begin
    sel_d       = sel_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    for (int l = 0; l < 2; l++) begin
      wr_ptr_d[l] = wr_ptr_q[l];
      rd_ptr_d[l] = rd_ptr_q[l];
      cnt_d[l]    = cnt_q[l];
      ovf_d[l]    = ovf_q[l] | (vin[l] & ~wr[l]);
      if (wr[l]) wr_ptr_d[l] = wr_ptr_q[l] + PTR_W'(1);
      if (rd[l]) rd_ptr_d[l] = rd_ptr_q[l] + PTR_W'(1);
      if (wr[l] && !rd[l])      cnt_d[l] = cnt_q[l] + CNT_W'(1);
      else if (rd[l] && !wr[l]) cnt_d[l] = cnt_q[l] - CNT_W'(1);
    end
    if (rd[0] || rd[1]) begin
      data_out_d  = mem_q[sel_idx][rd_ptr_q[sel_idx]];
      valid_out_d = 1'b1;
      sel_d       = (sel_q == LANE0) ? LANE1 : LANE0;
    end
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      sel_q       <= LANE0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        cnt_q[l]    <= '0;
        ovf_q[l]    <= 1'b0;
      end
    end else begin
      sel_q       <= sel_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= wr_ptr_d[l];
        rd_ptr_q[l] <= rd_ptr_d[l];
        cnt_q[l]    <= cnt_d[l];
        ovf_q[l]    <= ovf_d[l];
      end
    end
  end

  // Storage needs no reset: occupancy is governed entirely by the counters.
  always_ff @(posedge clk_2f) begin
    for (int l = 0; l < 2; l++) begin
      if (wr[l]) mem_q[l][wr_ptr_q[l]] <= din[l];
    end
  end

  assign ready_0    = (cnt_q[0] != FULL);
  assign ready_1    = (cnt_q[1] != FULL);
  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign overflow_0 = ovf_q[0];
  assign overflow_1 = ovf_q[1];
  assign dbg_sel    = sel_q;

endmodule

// File: tb/tb_mux_unstriping.sv
// Bench for mux_unstriping: lane-queue reference model feeds an expected
// queue; a negedge monitor checks outputs against it.
module tb_mux_unstriping;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clk_2f = 1'b0;
  logic         reset;
  logic [W-1:0] data_in0, data_in1;
  logic         valid_in0, valid_in1;
  logic         ready_0, ready_1;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         overflow_0, overflow_1;
  logic         dbg_sel;

  mux_unstriping #(.DATA_W(W), .DEPTH(DEPTH)) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .data_in0   (data_in0),
    .valid_in0  (valid_in0),
    .data_in1   (data_in1),
    .valid_in1  (valid_in1),
    .ready_0    (ready_0),
    .ready_1    (ready_1),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .overflow_0 (overflow_0),
    .overflow_1 (overflow_1),
    .dbg_sel    (dbg_sel)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_2f = ~clk_2f;

  int cyc = 0;
  always @(posedge clk_2f) cyc++;

  // ---------------- reference model ----------------
  logic [W-1:0] lane0_q[$];
  logic [W-1:0] lane1_q[$];
  logic         m_sel;
  logic         m_ovf0, m_ovf1;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [W-1:0] last_exp;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    lane0_q.delete();
    lane1_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    m_sel    = 1'b0;
    m_ovf0   = 1'b0;
    m_ovf1   = 1'b0;
    last_exp = '0;
  endtask

  // One clock of behaviour: the selected lane's oldest word leaves first,
  // then arriving words join their lane if it has room (or just lost one).
  task automatic model_step(input logic v0, input logic [W-1:0] d0,
                            input logic v1, input logic [W-1:0] d1);
    bit popped0 = 0, popped1 = 0;
    if (m_sel == 1'b0 && lane0_q.size() > 0) begin
      exp_q.push_back(lane0_q.pop_front());
      exp_cyc_q.push_back(cyc + 1);
      popped0 = 1;
      m_sel   = 1'b1;
    end else if (m_sel == 1'b1 && lane1_q.size() > 0) begin
      exp_q.push_back(lane1_q.pop_front());
      exp_cyc_q.push_back(cyc + 1);
      popped1 = 1;
      m_sel   = 1'b0;
    end
    if (v0) begin
      if (lane0_q.size() < DEPTH) lane0_q.push_back(d0);
      else m_ovf0 = 1'b1;
    end
    if (v1) begin
      if (lane1_q.size() < DEPTH) lane1_q.push_back(d1);
      else m_ovf1 = 1'b1;
    end
    // a pop above already shrank the queue, so "size < DEPTH" covers write+read on full
    if (popped0 && lane0_q.size() > DEPTH) m_ovf0 = 1'b1;
    if (popped1 && lane1_q.size() > DEPTH) m_ovf1 = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  // Called at negedge+1; returns at the following negedge+1.
  task automatic step(input logic v0, input logic [W-1:0] d0,
                      input logic v1, input logic [W-1:0] d1);
    valid_in0 = v0; data_in0 = d0;
    valid_in1 = v1; data_in1 = d1;
    model_step(v0, d0, v1, d1);
    @(negedge clk_2f); #1;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_valid_out", W'(valid_out), W'(0));
    check("rst_data_out", data_out, '0);
    check("rst_ready_0", W'(ready_0), W'(1));
    check("rst_ready_1", W'(ready_1), W'(1));
    check("rst_overflow_0", W'(overflow_0), W'(0));
    check("rst_overflow_1", W'(overflow_1), W'(0));
    model_clear();
    @(posedge clk_2f); @(negedge clk_2f); #1;
    reset = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_2f) begin
    if (!reset) begin
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid_out", W'(valid_out), W'(0));
        end else begin
          last_exp = exp_q.pop_front();
          check("data_out", data_out, last_exp);
          check("out_cycle", W'(cyc), W'(exp_cyc_q.pop_front()));
        end
      end else begin
        check("held_data_out", data_out, last_exp);
      end
      check("ready_0", W'(ready_0), W'(lane0_q.size() != DEPTH));
      check("ready_1", W'(ready_1), W'(lane1_q.size() != DEPTH));
      check("overflow_0", W'(overflow_0), W'(m_ovf0));
      check("overflow_1", W'(overflow_1), W'(m_ovf1));
      check("sel", W'(dbg_sel), W'(m_sel));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    valid_in0 = 1'b0; valid_in1 = 1'b0;
    data_in0 = '0; data_in1 = '0;
    model_clear();
    @(negedge clk_2f); #1;
    do_reset();

    // in-order merge
    step(1'b1, 32'h1, 1'b0, '0);
    step(1'b0, '0, 1'b1, 32'h2);
    step(1'b1, 32'h3, 1'b0, '0);
    step(1'b0, '0, 1'b1, 32'h4);
    idle(3);

    // skew: lane 1 ahead of lane 0
    step(1'b0, '0, 1'b1, 32'hBBBB0001);
    idle(2);
    step(1'b1, 32'hAAAA0000, 1'b0, '0);
    idle(3);

    // starvation hold on lane 1
    step(1'b1, 32'h11, 1'b0, '0);
    idle(5);
    step(1'b0, '0, 1'b1, 32'h22);
    idle(2);

    // overflow on lane 1 with lane 0 empty, then drain
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 32'h100 + W'(i));
    check("ovf_ready_1", W'(ready_1), W'(0));
    check("ovf_flag_1", W'(overflow_1), W'(1));
    check("ovf_flag_0", W'(overflow_0), W'(0));
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h200 + W'(i), 1'b0, '0);
    idle(8);

    // full lane 0 with sel on lane 0, write while popping
    do_reset();
    step(1'b1, 32'h300, 1'b0, '0);
    idle(1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h310 + W'(i), 1'b0, '0);
    step(1'b0, '0, 1'b1, 32'h400);
    idle(1);
    step(1'b1, 32'hDEAD, 1'b0, '0);
    check("full_wr_rd_ready_0", W'(ready_0), W'(0));
    check("full_wr_rd_ovf_0", W'(overflow_0), W'(0));
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 32'h410 + W'(i));
    idle(12);

    // random traffic with varying lane rates and occasional mid-stream reset
    for (int blk = 0; blk < 15; blk++) begin
      int r0 = $urandom_range(10, 90);
      int r1 = $urandom_range(10, 90);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        step(($urandom_range(0, 99) < r0), W'($urandom),
             ($urandom_range(0, 99) < r1), W'($urandom));
      end
    end

    // drain: feed whichever lane is starving so every buffered word leaves
    for (int i = 0; i < 40; i++) step(1'b1, W'($urandom), 1'b1, W'($urandom));
    idle(2 * DEPTH + 4);
    for (int i = 0; i < 2; i++) step(!m_sel, W'($urandom), m_sel, W'($urandom));
    idle(4);
    check("exp_q_leftover", W'(exp_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
